udp_axis_slave: RTL and testbench

Bridges a generic AXI-Stream source onto the UDP transmit path. Every accepted input beat becomes one UDP datagram. The datagram carries a 32-bit big-endian transfer ID followed by the beat's valid data bytes. The block sits between a user data producer and the UDP/IP transmit stack, driving that stack's header and byte-wide payload interfaces.

---
 rtl/udp_axis_slave.sv | 164 ++++++++++++++++
 tb/tb_udp_axis_slave.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/udp_axis_slave.sv
// AXI-Stream to UDP transmit bridge: each accepted input beat becomes one datagram
// carrying a 32-bit big-endian transfer ID followed by the beat's kept data bytes.
module udp_axis_slave #(
  parameter logic [15:0] UDP_PORT    = 16'd1234,
  parameter logic [31:0] LOCAL_IP    = 32'hC0A80180,
  parameter logic [31:0] TARGET_IP   = 32'hC0A80101,
  parameter logic [7:0]  IP_TTL      = 8'd64,
  parameter int unsigned TDATA_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  // UDP transmit header channel
  output logic                     udp_tx_header_valid,
  input  logic                     udp_tx_header_ready,
  output logic [5:0]               udp_tx_header_ip_dscp,
  output logic [1:0]               udp_tx_header_ip_ecn,
  output logic [7:0]               udp_tx_header_ip_ttl,
  output logic [31:0]              udp_tx_header_ip_source_ip,
  output logic [31:0]              udp_tx_header_ip_dest_ip,
  output logic [15:0]              udp_tx_header_source_port,
  output logic [15:0]              udp_tx_header_dest_port,
  output logic [15:0]              udp_tx_header_length,
  output logic [15:0]              udp_tx_header_checksum,
  // UDP transmit payload channel
  output logic [7:0]               udp_tx_payload_tdata,
  output logic                     udp_tx_payload_tvalid,
  input  logic                     udp_tx_payload_tready,
  output logic                     udp_tx_payload_tlast,
  output logic                     udp_tx_payload_tuser,
  // Input stream
  input  logic [TDATA_WIDTH-1:0]   in_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] in_axis_tkeep,
  input  logic                     in_axis_tuser,
  input  logic                     in_axis_tlast,
  input  logic                     in_axis_tvalid,
  output logic                     in_axis_tready
);

  localparam int unsigned KW = TDATA_WIDTH / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_nx;
  logic [TDATA_WIDTH-1:0] data_q;
  logic [KW-1:0]          keep_q, keep_rem;
  logic                   user_q;
  logic [31:0]            id_q;
  logic [2:0]             id_cnt;
  logic                   hdr_valid, pay_valid, hdr_done, pay_done;

  logic                   accept, hdr_fire, pay_fire, pay_last, finish;
  logic                   id_phase, more_lanes, found;
  logic [7:0]             lane_byte, id_byte;
  logic [15:0]            n_keep;
  logic                   unused_tlast;

  // Input tlast carries no meaning here: every beat is its own datagram.
  assign unused_tlast = in_axis_tlast;

  assign in_axis_tready = (state == IDLE) && reset;
  assign accept         = in_axis_tvalid && in_axis_tready;
  assign hdr_fire       = hdr_valid && udp_tx_header_ready;
  assign pay_fire       = pay_valid && udp_tx_payload_tready;
  assign finish         = (state == BUSY) && (hdr_done || hdr_fire) && (pay_done || (pay_fire && pay_last));

  // Data bytes come from the lowest still-pending kept lane; sent lanes are cleared.
  assign id_phase   = ~id_cnt[2];
  assign more_lanes = |(keep_rem & (keep_rem - KW'(1)));
  assign pay_last   = id_phase ? ((id_cnt == 3'd3) && (keep_rem == '0)) : ~more_lanes;

  always_comb begin
    lane_byte = '0;
    found     = 1'b0;
    n_keep    = '0;
    for (int unsigned i = 0; i < KW; i++) begin
      if (!found && keep_rem[i]) begin
        lane_byte = data_q[8*i +: 8];
        found     = 1'b1;
      end
      n_keep = n_keep + 16'(keep_q[i]);
    end
  end

  always_comb begin
    case (id_cnt[1:0])
      2'd0:    id_byte = id_q[31:24];
      2'd1:    id_byte = id_q[23:16];
      2'd2:    id_byte = id_q[15:8];
      default: id_byte = id_q[7:0];
    endcase
  end

  assign udp_tx_header_valid        = hdr_valid;
  assign udp_tx_header_ip_dscp      = '0;
  assign udp_tx_header_ip_ecn       = '0;
  assign udp_tx_header_ip_ttl       = IP_TTL;
  assign udp_tx_header_ip_source_ip = LOCAL_IP;
  assign udp_tx_header_ip_dest_ip   = TARGET_IP;
  assign udp_tx_header_source_port  = UDP_PORT;
  assign udp_tx_header_dest_port    = UDP_PORT;
  assign udp_tx_header_length       = 16'd12 + n_keep;
  assign udp_tx_header_checksum     = '0;

  assign udp_tx_payload_tvalid = pay_valid;
  assign udp_tx_payload_tdata  = id_phase ? id_byte : lane_byte;
  assign udp_tx_payload_tlast  = pay_valid && pay_last;
  assign udp_tx_payload_tuser  = pay_valid && pay_last && user_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      keep_q    <= '0;
      keep_rem  <= '0;
      user_q    <= 1'b0;
      id_q      <= '0;
      id_cnt    <= '0;
      hdr_valid <= 1'b0;
      pay_valid <= 1'b0;
      hdr_done  <= 1'b0;
      pay_done  <= 1'b0;
    end else if (accept) begin
      data_q    <= in_axis_tdata;
      keep_q    <= in_axis_tkeep;
      keep_rem  <= in_axis_tkeep;
      user_q    <= in_axis_tuser;
      id_cnt    <= '0;
      hdr_valid <= 1'b1;
      pay_valid <= 1'b1;
      hdr_done  <= 1'b0;
      pay_done  <= 1'b0;
    end else if (state == BUSY) begin
      if (hdr_fire) begin
        hdr_valid <= 1'b0;
        hdr_done  <= 1'b1;
      end
      if (pay_fire) begin
        if (pay_last) begin
          pay_valid <= 1'b0;
          pay_done  <= 1'b1;
        end else if (id_phase) begin
          id_cnt <= id_cnt + 3'd1;
        end else begin
          keep_rem <= keep_rem & (keep_rem - KW'(1));
        end
      end
      if (finish) id_q <= id_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_udp_axis_slave.sv
// Directed bench for udp_axis_slave (16-bit input): checks header fields, payload
// byte order, ID sequencing, sparse/empty tkeep, backpressure and mid-datagram reset.
module tb_udp_axis_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        hdr_valid, hdr_ready;
  logic [5:0]  hdr_dscp;
  logic [1:0]  hdr_ecn;
  logic [7:0]  hdr_ttl;
  logic [31:0] hdr_sip, hdr_dip;
  logic [15:0] hdr_sport, hdr_dport, hdr_len, hdr_csum;
  logic [7:0]  pay_tdata;
  logic        pay_tvalid, pay_tready, pay_tlast, pay_tuser;
  logic [15:0] in_tdata;
  logic [1:0]  in_tkeep;
  logic        in_tuser, in_tlast, in_tvalid, in_tready;

  int          ncmp = 0;
  int          nfail = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  udp_axis_slave #(.TDATA_WIDTH(16)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .udp_tx_header_valid        (hdr_valid),
    .udp_tx_header_ready        (hdr_ready),
    .udp_tx_header_ip_dscp      (hdr_dscp),
    .udp_tx_header_ip_ecn       (hdr_ecn),
    .udp_tx_header_ip_ttl       (hdr_ttl),
    .udp_tx_header_ip_source_ip (hdr_sip),
    .udp_tx_header_ip_dest_ip   (hdr_dip),
    .udp_tx_header_source_port  (hdr_sport),
    .udp_tx_header_dest_port    (hdr_dport),
    .udp_tx_header_length       (hdr_len),
    .udp_tx_header_checksum     (hdr_csum),
    .udp_tx_payload_tdata       (pay_tdata),
    .udp_tx_payload_tvalid      (pay_tvalid),
    .udp_tx_payload_tready      (pay_tready),
    .udp_tx_payload_tlast       (pay_tlast),
    .udp_tx_payload_tuser       (pay_tuser),
    .in_axis_tdata              (in_tdata),
    .in_axis_tkeep              (in_tkeep),
    .in_axis_tuser              (in_tuser),
    .in_axis_tlast              (in_tlast),
    .in_axis_tvalid             (in_tvalid),
    .in_axis_tready             (in_tready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [31:0] id, input int nb, input logic [7:0] b0, input logic [7:0] b1);
    exp_q.delete();
    exp_q.push_back(id[31:24]);
    exp_q.push_back(id[23:16]);
    exp_q.push_back(id[15:8]);
    exp_q.push_back(id[7:0]);
    if (nb > 0) exp_q.push_back(b0);
    if (nb > 1) exp_q.push_back(b1);
  endtask

  task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic u);
    int n = 0;
    @(negedge clk);
    in_tdata  = d;
    in_tkeep  = k;
    in_tuser  = u;
    in_tlast  = 1'b1;
    in_tvalid = 1'b1;
    while (!in_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accept_ready", in_tready, 1'b1);
    @(posedge clk);
    #1 in_tvalid = 1'b0;
  endtask

  task automatic run_datagram(input logic exp_user, input logic [15:0] exp_len,
                              input int hdr_delay, input bit rnd);
    int cyc = 0;
    int idx = 0;
    bit hdr_seen = 0;
    while (!(hdr_seen && idx == exp_q.size()) && cyc < 200) begin
      @(negedge clk);
      pay_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hdr_ready  = (cyc >= hdr_delay);
      #1;
      chk("in_tready_busy", in_tready, 1'b0);
      if (hdr_seen) chk("hdr_valid_after_fire", hdr_valid, 1'b0);
      else if (hdr_valid) begin
        chk("hdr_length", hdr_len, exp_len);
        chk("hdr_checksum", hdr_csum, 16'h0000);
        chk("hdr_ports", {hdr_sport, hdr_dport}, {16'd1234, 16'd1234});
        chk("hdr_ips", {hdr_sip, hdr_dip}, {32'hC0A80180, 32'hC0A80101});
        chk("hdr_ttl_dscp_ecn", {hdr_ttl, hdr_dscp, hdr_ecn}, {8'd64, 6'd0, 2'd0});
        if (hdr_ready) hdr_seen = 1;
      end
      if (idx >= exp_q.size()) chk("pay_valid_after_last", pay_tvalid, 1'b0);
      else if (pay_tvalid) begin
        chk("pay_byte", pay_tdata, exp_q[idx]);
        chk("pay_tlast", pay_tlast, (idx == exp_q.size() - 1));
        chk("pay_tuser", pay_tuser, (idx == exp_q.size() - 1) ? exp_user : 1'b0);
        if (pay_tready) idx++;
      end
      @(posedge clk);
      cyc++;
    end
    chk("datagram_complete", {hdr_seen, 8'(idx)}, {1'b1, 8'(exp_q.size())});
    @(negedge clk);
    pay_tready = 1'b0;
    hdr_ready  = 1'b0;
    #1 chk("in_tready_after", in_tready, 1'b1);
  endtask

  initial begin
    reset      = 1'b0;
    hdr_ready  = 1'b0;
    pay_tready = 1'b0;
    in_tdata   = '0;
    in_tkeep   = '0;
    in_tuser   = 1'b0;
    in_tlast   = 1'b0;
    in_tvalid  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_tready", in_tready, 1'b0);
    chk("rst_valids", {hdr_valid, pay_tvalid}, 2'b00);
    chk("rst_tlast_tuser", {pay_tlast, pay_tuser}, 2'b00);
    chk("rst_length", hdr_len, 16'd12);
    reset = 1'b1;
    #1 chk("post_rst_in_tready", in_tready, 1'b1);

    // Format and header: ID 0, A55A full keep
    send_beat(16'hA55A, 2'b11, 1'b0);
    set_exp(32'd0, 2, 8'h5A, 8'hA5);
    run_datagram(1'b0, 16'd14, 0, 0);

    // Consecutive beats: IDs 1, 2
    send_beat(16'h1234, 2'b11, 1'b1);
    set_exp(32'd1, 2, 8'h34, 8'h12);
    run_datagram(1'b1, 16'd14, 0, 0);
    send_beat(16'h5678, 2'b11, 1'b0);
    set_exp(32'd2, 2, 8'h78, 8'h56);
    run_datagram(1'b0, 16'd14, 2, 0);

    // Sparse keep: only upper lane
    send_beat(16'hBEEF, 2'b10, 1'b0);
    set_exp(32'd3, 1, 8'hBE, 8'h00);
    run_datagram(1'b0, 16'd13, 0, 0);

    // Empty keep: ID only, tuser on the 4th byte
    send_beat(16'hFFFF, 2'b00, 1'b1);
    set_exp(32'd4, 0, 8'h00, 8'h00);
    run_datagram(1'b1, 16'd12, 0, 0);

    // Header held off for 20 cycles, lower lane only
    send_beat(16'h7788, 2'b01, 1'b0);
    set_exp(32'd5, 1, 8'h88, 8'h00);
    run_datagram(1'b0, 16'd13, 20, 0);

    // Random payload ready
    send_beat(16'hC3D4, 2'b11, 1'b1);
    set_exp(32'd6, 2, 8'hD4, 8'hC3);
    run_datagram(1'b1, 16'd14, 3, 1);

    // Reset mid-payload
    send_beat(16'h9999, 2'b11, 1'b0);
    @(negedge clk);
    pay_tready = 1'b1;
    hdr_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_valids", {hdr_valid, pay_tvalid}, 2'b00);
    chk("midrst_tlast", pay_tlast, 1'b0);
    chk("midrst_in_tready", in_tready, 1'b0);
    pay_tready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send_beat(16'h1122, 2'b11, 1'b0);
    set_exp(32'd0, 2, 8'h22, 8'h11);
    run_datagram(1'b0, 16'd14, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
